accum_scheduler: RTL and testbench
==================================

ACCUM_SCHEDULER -- requirements
Module: accum_scheduler

Interface
REQ-001 The block SHALL have parameter N_CH, default 4, number of TDC requester channels (fixed 4 in this revision).
REQ-002 The block SHALL have parameter WIN_LEN, default 10, samples per accumulation window, legal range 1..15.
REQ-003 The block SHALL have parameter OFFSET, default 18, per-sample additive correction (16-bit unsigned).
REQ-004 The block SHALL have parameter TIMEOUT, default 64, idle cycles tolerated inside a window, legal range 1..255.
REQ-005 The block SHALL have port clk  input  1  sole clock, rising edge.
REQ-006 The block SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-007 The block SHALL have port enable  input  1  permits new grants when high.
REQ-008 The block SHALL have port ch_valid  input  4  per-channel sample valid.
REQ-009 The block SHALL have port ch_data  input  64  four 16-bit unsigned samples, channel k at bits [16k+15:16k].
REQ-010 The block SHALL have port ch_ready  output  4  one-hot accept strobe to the granted channel.
REQ-011 The block SHALL have port result  output  20  last completed (or aborted) window sum.
REQ-012 The block SHALL have port result_ch  output  2  channel that produced result.
REQ-013 The block SHALL have port result_count  output  4  samples contained in result.
REQ-014 The block SHALL have port result_aborted  output  1  result came from a timed-out window.
REQ-015 The block SHALL have port result_valid  output  1  one-cycle pulse when result updates.

Function
REQ-016 The block SHALL implement states IDLE and ACCUM, shared single 20-bit accumulator.
REQ-017 In IDLE with enable=1 and any ch_valid high, the block SHALL grant the first requesting channel in round-robin order starting at (last_served+1) mod 4 and enter ACCUM next cycle, clearing sum, sample counter and stall counter.
REQ-018 In IDLE with enable=0 or no ch_valid high, the block SHALL remain in IDLE with ch_ready=0.
REQ-019 In ACCUM, ch_ready SHALL be high only for the granted channel, combinationally from state; all other ready bits 0.
REQ-020 A sample SHALL be accepted on a rising edge where ch_valid[g] and ch_ready[g] are both high; sum <= sum + data + OFFSET, counter increments, stall counter clears.
REQ-021 Each cycle in ACCUM without acceptance SHALL increment the stall counter.
REQ-022 On the accept completing the WIN_LEN-th sample, the block SHALL register result = final sum, result_ch = g, result_count = WIN_LEN, result_aborted = 0, pulse result_valid the following cycle, record last_served = g, return to IDLE.
REQ-023 When the stall counter reaches TIMEOUT, the block SHALL register result = partial sum, result_count = accepted samples (0 allowed), result_aborted = 1, pulse result_valid, record last_served = g, return to IDLE.
REQ-024 Latency: result_valid SHALL be high in the cycle immediately after the completing accept or timeout edge, exactly one cycle long.
REQ-025 result, result_ch, result_count, result_aborted SHALL hold their values until the next result_valid pulse.
REQ-026 Arithmetic SHALL be unsigned, 20-bit; with WIN_LEN<=15 no overflow occurs (max 983295); no saturation logic.
REQ-027 Deasserting enable during ACCUM SHALL NOT abort the current window; it only blocks the next grant.
REQ-028 Deasserting ch_valid of the granted channel SHALL only stall; requests from other channels SHALL be ignored until return to IDLE.
REQ-029 An IDLE cycle SHALL always separate consecutive windows (no back-to-back grant on the completing edge).

Reset
REQ-030 Asserting rst at any time, including mid-window, SHALL immediately force IDLE, ch_ready=0, result=0, result_ch=0, result_count=0, result_aborted=0, result_valid=0, last_served=3 (so channel 0 has first priority), discarding any partial sum.
REQ-031 After rst deasserts, the first grant SHALL occur no earlier than the first rising edge with rst low.

Verification
REQ-032 Channel 0 only, valid every cycle, data=100, defaults -> after 10 accepts result=1180, result_ch=0, result_count=10, result_aborted=0, single result_valid pulse.
REQ-033 All four channels valid continuously, data k=1000*k -> grants in order 0,1,2,3,0; results 180, 10180, 20180, 30180.
REQ-034 Channel 2 gives 3 samples of 0 then drops valid -> after 64 stalled cycles result=54, result_count=3, result_aborted=1, result_ch=2.
REQ-035 Channel 1 at sample 5 of a window, rst pulsed -> ch_ready=0 within same cycle, all result fields 0, next grant goes to lowest requesting channel from 0.
REQ-036 All channels data=65535, WIN_LEN=15 -> result=983295, no wrap; enable dropped mid-window -> window completes, no further grants.

Source files
------------

// File: rtl/accum_scheduler_if.sv
// accum_scheduler_if -- channel request/accept bus and window result bus.
//   enable         : permits new grants when high
//   ch_valid[3:0]  : per-channel sample valid
//   ch_data[63:0]  : four 16-bit samples, channel k at [16k+15:16k]
//   ch_ready[3:0]  : one-hot accept strobe to the granted channel
//   result[19:0]   : last completed or aborted window sum
//   result_ch[1:0] : channel that produced result
//   result_count   : samples contained in result
//   result_aborted : result came from a timed-out window
//   result_valid   : one-cycle pulse when the result fields update
// master = requesters/consumer side, slave = scheduler side.
interface accum_scheduler_if;
  logic        enable;
  logic [3:0]  ch_valid;
  logic [63:0] ch_data;
  logic [3:0]  ch_ready;
  logic [19:0] result;
  logic [1:0]  result_ch;
  logic [3:0]  result_count;
  logic        result_aborted;
  logic        result_valid;

  modport master (
    output enable, ch_valid, ch_data,
    input  ch_ready, result, result_ch, result_count, result_aborted, result_valid
  );

  modport slave (
    input  enable, ch_valid, ch_data,
    output ch_ready, result, result_ch, result_count, result_aborted, result_valid
  );
endinterface

// File: rtl/accum_scheduler.sv
// accum_scheduler -- round-robin grant of one TDC channel at a time into a
// shared 20-bit accumulator. Each window sums WIN_LEN samples (each corrected
// by +OFFSET) from the granted channel, or is aborted after TIMEOUT
// consecutive idle cycles. Results are registered and announced with a
// one-cycle result_valid pulse.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : accum_scheduler_if.slave (request/accept and result signals)
module accum_scheduler #(
  parameter int unsigned N_CH    = 4,
  parameter int unsigned WIN_LEN = 10,
  parameter int unsigned OFFSET  = 18,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  accum_scheduler_if.slave  bus
);

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t      state, state_next;
  logic [1:0]  grant;
  logic [1:0]  last_served;
  logic [1:0]  rr_pick;
  logic [1:0]  rr_idx;
  logic        rr_found;
  logic [19:0] sum;
  logic [19:0] sum_acc;
  logic [3:0]  count;
  logic [7:0]  stall;
  logic [15:0] sample;
  logic        accept;
  logic        win_done;
  logic        timed_out;

  // First requester scanning from last_served+1 upward, wrapping mod 4.
  always_comb begin
    rr_pick  = '0;
    rr_idx   = '0;
    rr_found = 1'b0;
    for (int unsigned i = 1; i <= N_CH; i++) begin
      rr_idx = last_served + 2'(i);
      if (!rr_found && bus.ch_valid[rr_idx]) begin
        rr_found = 1'b1;
        rr_pick  = rr_idx;
      end
    end
  end

  assign sample  = bus.ch_data[{grant, 4'b0000} +: 16];
  assign sum_acc = sum + 20'(sample) + 20'(OFFSET);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next   = state;
    bus.ch_ready = '0;
    accept       = 1'b0;
    win_done     = 1'b0;
    timed_out    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.enable && rr_found) state_next = ACCUM;
      end
      ACCUM: begin
        bus.ch_ready[grant] = 1'b1;
        accept    = bus.ch_valid[grant];
        win_done  = accept && (count == 4'(WIN_LEN - 1));
        // This edge is the TIMEOUT-th consecutive cycle without an accept.
        timed_out = !accept && (stall == 8'(TIMEOUT - 1));
        if (win_done || timed_out) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant              <= '0;
      last_served        <= 2'd3;
      sum                <= '0;
      count              <= '0;
      stall              <= '0;
      bus.result         <= '0;
      bus.result_ch      <= '0;
      bus.result_count   <= '0;
      bus.result_aborted <= 1'b0;
      bus.result_valid   <= 1'b0;
    end else begin
      bus.result_valid <= 1'b0;
      case (state)
        IDLE: begin
          sum   <= '0;
          count <= '0;
          stall <= '0;
          if (bus.enable && rr_found) grant <= rr_pick;
        end
        ACCUM: begin
          if (accept) begin
            sum   <= sum_acc;
            count <= count + 4'd1;
            stall <= '0;
          end else begin
            stall <= stall + 8'd1;
          end
          if (win_done || timed_out) begin
            bus.result         <= accept ? sum_acc : sum;
            bus.result_ch      <= grant;
            bus.result_count   <= accept ? count + 4'd1 : count;
            bus.result_aborted <= timed_out;
            bus.result_valid   <= 1'b1;
            last_served        <= grant;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_accum_scheduler.sv
module tb_accum_scheduler;

  typedef struct {
    logic [19:0] result;
    logic [1:0]  ch;
    logic [3:0]  count;
    logic        aborted;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t exp_a[$];
  exp_t exp_b[$];
  logic prev_a = 1'b0;
  logic prev_b = 1'b0;

  always #5 clk = ~clk;

  accum_scheduler_if bus_a ();
  accum_scheduler_if bus_b ();

  accum_scheduler #(.N_CH(4), .WIN_LEN(10), .OFFSET(18), .TIMEOUT(64)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a.slave)
  );

  accum_scheduler #(.N_CH(4), .WIN_LEN(15), .OFFSET(18), .TIMEOUT(64)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b.slave)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_a(input logic [19:0] r, input logic [1:0] c,
                        input logic [3:0] n, input logic ab);
    exp_t e;
    e.result = r; e.ch = c; e.count = n; e.aborted = ab;
    exp_a.push_back(e);
  endtask

  // Scoreboard monitors: pop one expected entry per result_valid pulse.
  always @(negedge clk) begin
    if (!rst && bus_a.result_valid) begin
      exp_t e;
      check("a_pulse_single", 32'(prev_a), 32'd0);
      if (exp_a.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL a_unexpected_result: got result %0d ch %0d expected none",
                 bus_a.result, bus_a.result_ch);
      end else begin
        e = exp_a.pop_front();
        check("a_result",  32'(bus_a.result),         32'(e.result));
        check("a_ch",      32'(bus_a.result_ch),      32'(e.ch));
        check("a_count",   32'(bus_a.result_count),   32'(e.count));
        check("a_aborted", 32'(bus_a.result_aborted), 32'(e.aborted));
      end
    end
    prev_a = bus_a.result_valid;
  end

  always @(negedge clk) begin
    if (!rst && bus_b.result_valid) begin
      exp_t e;
      check("b_pulse_single", 32'(prev_b), 32'd0);
      if (exp_b.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL b_unexpected_result: got result %0d expected none", bus_b.result);
      end else begin
        e = exp_b.pop_front();
        check("b_result",  32'(bus_b.result),         32'(e.result));
        check("b_ch",      32'(bus_b.result_ch),      32'(e.ch));
        check("b_count",   32'(bus_b.result_count),   32'(e.count));
        check("b_aborted", 32'(bus_b.result_aborted), 32'(e.aborted));
      end
    end
    prev_b = bus_b.result_valid;
  end

  // Waits at negedges for a result pulse on dut_a; drops enable on the
  // pulse cycle when asked so no new window starts.
  task automatic wait_result_a(input string name, input int budget, input bit stop);
    int k = 0;
    while (k < budget) begin
      @(negedge clk);
      if (bus_a.result_valid) break;
      k++;
    end
    if (k >= budget) begin
      n_checks++; n_fail++;
      $display("FAIL %s: got no result_valid expected one within %0d cycles", name, budget);
    end
    if (stop) begin
      bus_a.enable   = 1'b0;
      bus_a.ch_valid = '0;
    end
  endtask

  task automatic wait_grant_a(input string name, input int ch);
    int k = 0;
    while (k < 20) begin
      @(posedge clk); #1;
      if (bus_a.ch_ready[ch]) break;
      k++;
    end
    if (k >= 20) begin
      n_checks++; n_fail++;
      $display("FAIL %s: got no grant expected ch %0d", name, ch);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    rst            = 1'b1;
    bus_a.enable   = 1'b0;
    bus_a.ch_valid = '0;
    bus_a.ch_data  = '0;
    bus_b.enable   = 1'b0;
    bus_b.ch_valid = '0;
    bus_b.ch_data  = '0;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_ready",   32'(bus_a.ch_ready),       32'd0);
    check("rst_result",  32'(bus_a.result),         32'd0);
    check("rst_ch",      32'(bus_a.result_ch),      32'd0);
    check("rst_count",   32'(bus_a.result_count),   32'd0);
    check("rst_aborted", 32'(bus_a.result_aborted), 32'd0);
    check("rst_valid",   32'(bus_a.result_valid),   32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Channel 0 alone, data 100: 10 * 118
    bus_a.ch_data  = {16'd0, 16'd0, 16'd0, 16'd100};
    bus_a.ch_valid = 4'b0001;
    bus_a.enable   = 1'b1;
    push_a(20'd1180, 2'd0, 4'd10, 1'b0);
    wait_result_a("ch0_window", 40, 1'b1);
    @(negedge clk);
    check("idle_after_done", 32'(bus_a.ch_ready), 32'd0);

    // All four channels continuous: grants 0,1,2,3,0
    do_reset();
    bus_a.ch_data  = {16'd3000, 16'd2000, 16'd1000, 16'd0};
    push_a(20'd180,   2'd0, 4'd10, 1'b0);
    push_a(20'd10180, 2'd1, 4'd10, 1'b0);
    push_a(20'd20180, 2'd2, 4'd10, 1'b0);
    push_a(20'd30180, 2'd3, 4'd10, 1'b0);
    push_a(20'd180,   2'd0, 4'd10, 1'b0);
    bus_a.ch_valid = 4'b1111;
    bus_a.enable   = 1'b1;
    for (int w = 0; w < 5; w++) wait_result_a("rr_window", 40, w == 4);

    // Channel 2: three zero samples, then stall to timeout.
    // Channel 0 requests meanwhile and must be ignored.
    do_reset();
    bus_a.ch_data  = '0;
    bus_a.ch_valid = 4'b0100;
    bus_a.enable   = 1'b1;
    wait_grant_a("ch2_grant", 2);
    check("ch2_ready_onehot", 32'(bus_a.ch_ready), 32'b0100);
    repeat (3) @(posedge clk);
    #1;
    bus_a.ch_valid = 4'b0001;
    push_a(20'd54, 2'd2, 4'd3, 1'b1);
    @(posedge clk); #1;
    check("ch2_ignores_others", 32'(bus_a.ch_ready), 32'b0100);
    wait_result_a("ch2_timeout", 100, 1'b1);

    // Channel 1 mid-window reset, then ch1/ch3 requesting: ch1 wins from 0.
    bus_a.ch_data  = {16'd0, 16'd0, 16'd7, 16'd0};
    bus_a.ch_valid = 4'b0010;
    bus_a.enable   = 1'b1;
    wait_grant_a("ch1_grant", 1);
    repeat (4) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("midrst_ready",   32'(bus_a.ch_ready),       32'd0);
    check("midrst_result",  32'(bus_a.result),         32'd0);
    check("midrst_ch",      32'(bus_a.result_ch),      32'd0);
    check("midrst_count",   32'(bus_a.result_count),   32'd0);
    check("midrst_aborted", 32'(bus_a.result_aborted), 32'd0);
    check("midrst_valid",   32'(bus_a.result_valid),   32'd0);
    @(posedge clk); #1;
    bus_a.ch_valid = 4'b1010;
    rst = 1'b0;
    wait_grant_a("post_rst_grant", 1);
    check("post_rst_ready", 32'(bus_a.ch_ready), 32'b0010);
    bus_a.enable   = 1'b0;
    bus_a.ch_valid = '0;
    do_reset();

    // Max-value window on WIN_LEN=15 instance; enable drops mid-window.
    bus_b.ch_data = {4{16'hFFFF}};
    begin
      exp_t e;
      e.result = 20'd983295; e.ch = 2'd0; e.count = 4'd15; e.aborted = 1'b0;
      exp_b.push_back(e);
    end
    bus_b.ch_valid = 4'b1111;
    bus_b.enable   = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    bus_b.enable = 1'b0;
    begin
      int k = 0;
      while (k < 40) begin
        @(negedge clk);
        if (bus_b.result_valid) break;
        k++;
      end
      if (k >= 40) begin
        n_checks++; n_fail++;
        $display("FAIL b_window: got no result_valid expected one within 40 cycles");
      end
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("b_no_grant_when_disabled", 32'(bus_b.ch_ready), 32'd0);
    end

    repeat (3) @(negedge clk);
    check("a_queue_drained", 32'(exp_a.size()), 32'd0);
    check("b_queue_drained", 32'(exp_b.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
